// File: rtl/delay.sv
// delay: fixed-latency data delay built as a circular buffer ("FIFO") or a flop chain ("REGISTERS")
module delay #(
   parameter string DELAY_TYPE   = "FIFO",
   parameter int    DATA_WIDTH   = 8,
   parameter int    DELAY_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  data_valid
);
   localparam int CW = $clog2(DELAY_CYCLES + 1);
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] src;
   logic                  valid_next;
   // dout stays zero until the first post-reset sample arrives, hiding stale buffer contents
   assign valid_next = data_valid | (cnt == CW'(DELAY_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         data_valid <= 1'b0;
         dout       <= '0;
      end else begin
         cnt        <= valid_next ? cnt : cnt + CW'(1);
         data_valid <= valid_next;
         dout       <= valid_next ? src : '0;
      end
   end
   if (DELAY_CYCLES < 1) begin : g_bad_len
      $error("delay: DELAY_CYCLES must be >= 1");
   end
   if (DELAY_TYPE != "FIFO" && DELAY_TYPE != "REGISTERS") begin : g_bad_type
      $error("delay: DELAY_TYPE must be FIFO or REGISTERS");
   end
   if (DELAY_CYCLES == 1) begin : g_direct
      assign src = din;
   end else if (DELAY_TYPE == "FIFO") begin : g_fifo
      localparam int N  = DELAY_CYCLES - 1;
      localparam int PW = N > 1 ? $clog2(N) : 1;
      logic [DATA_WIDTH-1:0] mem [N];
      logic [PW-1:0]         ptr;
      // read-before-write at one address gives exactly N buffered samples
      assign src = mem[ptr];
      always_ff @(posedge clk) ptr <= (rst || ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
      always_ff @(posedge clk) mem[ptr] <= din;
   end else begin : g_regs
      logic [DATA_WIDTH-1:0] stage [DELAY_CYCLES-1];
      assign src = stage[DELAY_CYCLES-2];
      always_ff @(posedge clk) begin
         if (rst) begin
            stage <= '{default: '0};
         end else begin
            stage[0] <= din;
            for (int i = 1; i < DELAY_CYCLES - 1; i++) stage[i] <= stage[i-1];
         end
      end
   end
endmodule

// File: tb/tb_delay.sv
// tb_delay: directed vector table plus hand sequences across several delay/mode instances
module tb_delay;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic [7:0] dout [7];
   logic       valid [7];
   localparam int DL [7] = '{4, 4, 1, 1, 5, 5, 7};
   string nm [7] = '{"f4", "r4", "f1", "r1", "f5", "r5", "f7"};
   int tests = 0, fails = 0;
   int e = 0, last_rst = 0;
   logic [7:0] hist [1024];

   always #5 clk = ~clk;

   delay #(.DELAY_TYPE("FIFO"),      .DATA_WIDTH(8), .DELAY_CYCLES(4)) u_f4 (.clk(clk), .rst(rst), .din(din), .dout(dout[0]), .data_valid(valid[0]));
   delay #(.DELAY_TYPE("REGISTERS"), .DATA_WIDTH(8), .DELAY_CYCLES(4)) u_r4 (.clk(clk), .rst(rst), .din(din), .dout(dout[1]), .data_valid(valid[1]));
   delay #(.DELAY_TYPE("FIFO"),      .DATA_WIDTH(8), .DELAY_CYCLES(1)) u_f1 (.clk(clk), .rst(rst), .din(din), .dout(dout[2]), .data_valid(valid[2]));
   delay #(.DELAY_TYPE("REGISTERS"), .DATA_WIDTH(8), .DELAY_CYCLES(1)) u_r1 (.clk(clk), .rst(rst), .din(din), .dout(dout[3]), .data_valid(valid[3]));
   delay #(.DELAY_TYPE("FIFO"),      .DATA_WIDTH(8), .DELAY_CYCLES(5)) u_f5 (.clk(clk), .rst(rst), .din(din), .dout(dout[4]), .data_valid(valid[4]));
   delay #(.DELAY_TYPE("REGISTERS"), .DATA_WIDTH(8), .DELAY_CYCLES(5)) u_r5 (.clk(clk), .rst(rst), .din(din), .dout(dout[5]), .data_valid(valid[5]));
   delay #(.DELAY_TYPE("FIFO"),      .DATA_WIDTH(8), .DELAY_CYCLES(7)) u_f7 (.clk(clk), .rst(rst), .din(din), .dout(dout[6]), .data_valid(valid[6]));

   typedef struct {
      logic       r;
      logic [7:0] d;
      logic [7:0] e4;
      logic       v4;
      logic [7:0] e1;
      logic       v1;
   } vec_t;
   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, e);
      end
   endtask

   // history model: after edge e, dout of a D-deep delay holds the sample captured at edge e-D+1
   task automatic step(input logic r, input logic [7:0] d);
      int  post;
      logic v;
      logic [7:0] x;
      rst = r;
      din = d;
      @(posedge clk);
      #1;
      e++;
      hist[e] = d;
      if (r) last_rst = e;
      post = e - last_rst;
      for (int k = 0; k < 7; k++) begin
         v = post >= DL[k];
         x = v ? hist[e - DL[k] + 1] : 8'h00;
         check({"model_valid_", nm[k]}, {31'd0, valid[k]}, {31'd0, v});
         check({"model_dout_", nm[k]}, {24'd0, dout[k]}, {24'd0, x});
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 8'hAB, 8'h00, 1'b0, 8'hAB, 1'b1};
      tbl[3]  = '{1'b0, 8'h11, 8'h00, 1'b0, 8'h11, 1'b1};
      tbl[4]  = '{1'b0, 8'h11, 8'h00, 1'b0, 8'h11, 1'b1};
      tbl[5]  = '{1'b0, 8'h11, 8'hAB, 1'b1, 8'h11, 1'b1};
      tbl[6]  = '{1'b0, 8'h11, 8'h11, 1'b1, 8'h11, 1'b1};
      tbl[7]  = '{1'b0, 8'h11, 8'h11, 1'b1, 8'h11, 1'b1};
      tbl[8]  = '{1'b0, 8'h5A, 8'h11, 1'b1, 8'h5A, 1'b1};
      tbl[9]  = '{1'b0, 8'hC3, 8'h11, 1'b1, 8'hC3, 1'b1};
      tbl[10] = '{1'b0, 8'h11, 8'h11, 1'b1, 8'h11, 1'b1};
      tbl[11] = '{1'b0, 8'h11, 8'h5A, 1'b1, 8'h11, 1'b1};
      tbl[12] = '{1'b0, 8'h11, 8'hC3, 1'b1, 8'h11, 1'b1};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].d);
         check("tbl_f4_dout",  {24'd0, dout[0]}, {24'd0, tbl[i].e4});
         check("tbl_f4_valid", {31'd0, valid[0]}, {31'd0, tbl[i].v4});
         check("tbl_r4_dout",  {24'd0, dout[1]}, {24'd0, tbl[i].e4});
         check("tbl_r4_valid", {31'd0, valid[1]}, {31'd0, tbl[i].v4});
         check("tbl_f1_dout",  {24'd0, dout[2]}, {24'd0, tbl[i].e1});
         check("tbl_f1_valid", {31'd0, valid[2]}, {31'd0, tbl[i].v1});
         check("tbl_r1_dout",  {24'd0, dout[3]}, {24'd0, tbl[i].e1});
         check("tbl_r1_valid", {31'd0, valid[3]}, {31'd0, tbl[i].v1});
      end
      // ramp: dout trails the sample just applied by D-1 edges, through many pointer wraps
      for (int i = 0; i < 60; i++) begin
         logic [7:0] x;
         x = 8'(i);
         step(1'b0, x);
         if (i >= 3) check("ramp_f4", {24'd0, dout[0]}, {24'd0, 8'(x - 8'd3)});
         if (i >= 6) check("ramp_f7", {24'd0, dout[6]}, {24'd0, 8'(x - 8'd6)});
      end
      // mid-stream reset: pre-reset data must never reappear during refill
      step(1'b1, 8'hFF);
      check("rst_f4_valid", {31'd0, valid[0]}, 32'd0);
      check("rst_f4_dout", {24'd0, dout[0]}, 32'd0);
      check("rst_r5_dout", {24'd0, dout[5]}, 32'd0);
      for (int j = 0; j < 8; j++) begin
         step(1'b0, 8'(8'hE0 + j));
         check("refill_f4_valid", {31'd0, valid[0]}, {31'd0, j >= 3});
         check("refill_f4_dout", {24'd0, dout[0]}, j >= 3 ? {24'd0, 8'(8'hE0 + j - 3)} : 32'd0);
         check("refill_r4_dout", {24'd0, dout[1]}, j >= 3 ? {24'd0, 8'(8'hE0 + j - 3)} : 32'd0);
         check("refill_f1_dout", {24'd0, dout[2]}, {24'd0, 8'(8'hE0 + j)});
      end
      // random stream exercising FIFO/REGISTERS equivalence at depth 5
      for (int i = 0; i < 200; i++) step(1'b0, 8'($urandom));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/delay.md
Name: delay

Overview:
- Fixed-latency pipeline delay for a data word.
- Every clock, the block accepts one sample on din and presents the sample from exactly DELAY_CYCLES clocks earlier on dout.
- data_valid indicates that dout carries a real post-reset sample.
- Used to align datapaths of differing latency.
- Two implementations are selectable, with identical cycle behaviour:
  - a circular-buffer memory ("FIFO"), for long delays;
  - a flop shift chain ("REGISTERS").

Parameters:
- DELAY_TYPE, "FIFO", implementation style: "FIFO" (circular buffer with wrapping pointer) or "REGISTERS" (shift-register chain). Any other value is an elaboration-time error.
- DATA_WIDTH, 8, width of din/dout in bits (>=1).
- DELAY_CYCLES, 4, latency in clocks (>=1). A value of 0 is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_WIDTH  sample captured on every rising edge (no enable).
- dout  output  DATA_WIDTH  registered delayed sample.
- data_valid  output  1  high when dout holds a sample captured after reset.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- Cycle t means the interval following rising edge t.
- Latency:
  - The din value present during cycle t is captured at edge t+1.
  - That value appears on dout during cycle t+DELAY_CYCLES.
  - Equivalently, dout(t) = din(t-DELAY_CYCLES).
- Throughput: one sample per clock, continuously; there is no stall or enable.
- Outputs are registered; no combinational path from din to dout.
- Reset (edge where rst=1):
  - dout <= 0, data_valid <= 0.
  - Fill counter and write/read pointer cleared to 0.
  - REGISTERS mode: all chain stages cleared to 0.
  - FIFO mode: memory contents need not be cleared.
  - The din value at the reset edge is discarded.
- Fill / valid:
  - A saturating counter counts the post-reset capture edges, starting from the first edge with rst=0.
  - data_valid rises when the first post-reset sample reaches dout, i.e. on the DELAY_CYCLES-th edge with rst=0.
  - data_valid stays high until the next reset.
  - While data_valid=0, dout is forced to 0, so stale FIFO memory is never visible.
- FIFO mode:
  - Buffer of DELAY_CYCLES-1 entries followed by the dout register. When DELAY_CYCLES=1 there is only the dout register.
  - A single pointer addresses the buffer.
  - Each edge: dout <= mem[ptr] and mem[ptr] <= din (read-before-write at the same address).
  - ptr wraps from DELAY_CYCLES-2 to 0, with no power-of-two requirement.
- REGISTERS mode: stage[0] <= din, stage[i] <= stage[i-1], and dout is the final stage.
- Reset mid-operation:
  - All in-flight samples are lost; data_valid drops to 0 on the reset edge.
  - Refill timing is identical to power-up.
- Both modes must produce bit-identical dout/data_valid sequences for any stimulus.

Test Plan:
- DELAY_TYPE="FIFO", DATA_WIDTH=8, DELAY_CYCLES=4.
  - Stimulus: rst high 2 cycles; then din=0xAB for 1 cycle, then din=0x11 held.
  - Required: data_valid=0 and dout=0x00 for cycles 0-3 after reset release.
  - Required: cycle 4 shows dout=0xAB with data_valid=1; cycle 5 onward shows dout=0x11.
- Ramp, DELAY_CYCLES=4: din = 0,1,2,... incrementing each clock -> once valid, dout = din-4 every cycle, including across the pointer wrap (ptr 2->0) repeated for 20+ cycles.
- Mode equivalence: the same random 200-sample stream into FIFO and REGISTERS instances (DELAY_CYCLES=5) -> identical dout and data_valid on every cycle.
- DELAY_CYCLES=1 in both modes, din=0x5A then 0xC3 -> dout=0x5A exactly one cycle after 0x5A is presented; data_valid high after the first post-reset edge.
- Mid-stream reset: pulse rst for 1 cycle after 10 valid samples.
  - Required: on the next cycle, data_valid=0 and dout=0.
  - Required: a full DELAY_CYCLES refill occurs before valid reasserts, with no pre-reset data ever appearing.
- DELAY_CYCLES=7 (not a power of two), FIFO mode, ramp input -> dout=din-7 with no skipped or repeated values over 50 cycles.
